// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer: FSM states, step direction,
// pattern modes and config-slave register addresses.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_STEP,
        ST_CLEAR
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic [1:0] CFG_CTRL    = 2'd0;
    localparam logic [1:0] CFG_PERIOD  = 2'd1;
    localparam logic [1:0] CFG_PATTERN = 2'd2;
    localparam logic [1:0] CFG_STATUS  = 2'd3;

endpackage

// File: rtl/led_pattern_next.sv
// Combinational next-pattern function: given the current LED image, the mode
// and the bounce direction, produce the image and direction for the next step.
module led_pattern_next
    import led_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic [1:0]  i_mode,
    input  logic [DW:0] i_cur,
    input  dir_e        i_dir,
    output logic [DW:0] o_cur,
    output dir_e        o_dir
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_cur = i_cur;
        o_dir = i_dir;
        case (i_mode)
            MODE_STATIC: o_cur = i_cur;
            MODE_BLINK:  o_cur = ~i_cur;
            MODE_ROTATE: o_cur = {i_cur[DW-1:0], i_cur[DW]};
            MODE_BOUNCE: begin
                // Reverse before a lit end bit would fall off, then shift the other way.
                if (i_dir == DIR_LEFT) begin
                    if (i_cur[DW]) begin
                        o_dir = DIR_RIGHT;
                        o_cur = {1'b0, i_cur[DW:1]};
                    end else begin
                        o_cur = {i_cur[DW-1:0], 1'b0};
                    end
                end else begin
                    if (i_cur[0]) begin
                        o_dir = DIR_LEFT;
                        o_cur = {i_cur[DW-1:0], 1'b0};
                    end else begin
                        o_cur = {1'b0, i_cur[DW:1]};
                    end
                end
            end
            default: o_cur = i_cur;
        endcase
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: CPU-programmed via cfg_* slave, issues
// single-cycle writes to the LED parallel port once per step period.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int               DW      = 9,
    parameter int               CNT_W   = 26,
    parameter logic [CNT_W-1:0] PER_RST = CNT_W'(50_000_000)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_read,
    input  logic        cfg_write,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  led_address,
    output logic [3:0]  led_byteenable,
    output logic        led_chipselect,
    output logic        led_write,
    output logic [31:0] led_writedata,
    output logic        busy
);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_en;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_term;
    logic [DW:0]      r_pattern;
    logic [DW:0]      r_cur;
    logic [DW:0]      w_cur_next;
    dir_e             r_dir;
    dir_e             w_dir_next;
    logic [15:0]      r_steps;
    logic             r_reload;
    logic             w_cfg_wr;
    logic             w_cfg_rd;
    logic [31:0]      w_rdata;

    assign w_cfg_wr = cfg_chipselect & cfg_write;
    assign w_cfg_rd = cfg_chipselect & cfg_read;
    assign w_term   = (r_period == '0) ? '0 : r_period - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            r_en      <= 1'b0;
            r_mode    <= MODE_STATIC;
            r_period  <= PER_RST;
            r_pattern <= '0;
        end else if (w_cfg_wr) begin
            case (cfg_address)
                CFG_CTRL: begin
                    r_en   <= cfg_writedata[0];
                    r_mode <= cfg_writedata[2:1];
                end
                CFG_PERIOD:  r_period  <= cfg_writedata[CNT_W-1:0];
                CFG_PATTERN: r_pattern <= cfg_writedata[DW:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_address)
            CFG_CTRL:    w_rdata = {29'd0, r_mode, r_en};
            CFG_PERIOD:  w_rdata = 32'(r_period);
            CFG_PATTERN: w_rdata = 32'(r_pattern);
            CFG_STATUS:  w_rdata = {r_steps, 15'd0, busy};
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_readdata <= '0;
        end else if (w_cfg_rd) begin
            cfg_readdata <= w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_en) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = r_en ? ST_WAIT : ST_CLEAR;
            ST_WAIT: begin
                // Compare with >= so a shortened PERIOD ends the wait at once.
                if (!r_en)                w_state_next = ST_CLEAR;
                else if (r_cnt >= w_term) w_state_next = ST_STEP;
            end
            ST_STEP:  w_state_next = r_en ? ST_WRITE : ST_CLEAR;
            ST_CLEAR: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    led_pattern_next #(.DW(DW)) u_next (
        .i_mode (r_mode),
        .i_cur  (r_cur),
        .i_dir  (r_dir),
        .o_cur  (w_cur_next),
        .o_dir  (w_dir_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur   <= '0;
            r_dir   <= DIR_LEFT;
            r_cnt   <= '0;
            r_steps <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_cur <= r_pattern;
                        r_dir <= DIR_LEFT;
                    end
                end
                ST_WRITE: begin
                    r_steps <= r_steps + 16'd1;
                    r_cnt   <= '0;
                end
                ST_WAIT: r_cnt <= r_cnt + CNT_W'(1);
                ST_STEP: begin
                    if (r_reload) begin
                        r_cur <= r_pattern;
                        r_dir <= DIR_LEFT;
                    end else begin
                        r_cur <= w_cur_next;
                        r_dir <= w_dir_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new PATTERN arriving while busy wins over consumption in the same STEP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= 1'b0;
        end else if (w_cfg_wr && cfg_address == CFG_PATTERN && r_state != ST_IDLE) begin
            r_reload <= 1'b1;
        end else if (r_state == ST_STEP || r_state == ST_IDLE) begin
            r_reload <= 1'b0;
        end
    end

    assign led_address    = 2'h0;
    assign led_byteenable = 4'hF;
    assign led_write      = (r_state == ST_WRITE) || (r_state == ST_CLEAR);
    assign led_chipselect = led_write;
    assign led_writedata  = (r_state == ST_WRITE) ? 32'(r_cur) : '0;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer: each task drives one scenario
// and compares LED-port traffic and config reads against hand-computed values.
module tb_led_pattern_sequencer;
    import led_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [1:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_read;
    logic        cfg_write;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  led_address;
    logic [3:0]  led_byteenable;
    logic        led_chipselect;
    logic        led_write;
    logic [31:0] led_writedata;
    logic        busy;

    int  n_vec = 0;
    int  n_miss = 0;
    int  cyc = 0;
    int  proto_err = 0;
    int  steps_base = 0;
    int  n_clear = 0;
    ev_t q[$];

    led_pattern_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_address    (cfg_address),
        .cfg_chipselect (cfg_chipselect),
        .cfg_read       (cfg_read),
        .cfg_write      (cfg_write),
        .cfg_writedata  (cfg_writedata),
        .cfg_readdata   (cfg_readdata),
        .led_address    (led_address),
        .led_byteenable (led_byteenable),
        .led_chipselect (led_chipselect),
        .led_write      (led_write),
        .led_writedata  (led_writedata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LED-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (led_write === 1'b1) begin
            q.push_back('{data: led_writedata, cyc: cyc});
            if (led_chipselect !== 1'b1 || led_address !== 2'h0 || led_byteenable !== 4'hF)
                proto_err++;
        end else if (led_chipselect !== 1'b0) begin
            proto_err++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] addr, input logic [31:0] data, output int c);
        @(posedge clk); #1;
        cfg_address = addr; cfg_writedata = data;
        cfg_chipselect = 1'b1; cfg_write = 1'b1;
        @(posedge clk); #1;
        c = cyc;
        cfg_chipselect = 1'b0; cfg_write = 1'b0;
    endtask

    task automatic cfg_rd(input logic [1:0] addr, output logic [31:0] d);
        @(posedge clk); #1;
        cfg_address = addr; cfg_chipselect = 1'b1; cfg_read = 1'b1;
        @(posedge clk); #1;
        d = cfg_readdata;
        cfg_chipselect = 1'b0; cfg_read = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name, output bit ok);
        int k = 0;
        while (q.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        ok = (q.size() >= target);
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL %s_timeout: got %0d writes, expected %0d", name, q.size(), target);
        end
    endtask

    function automatic logic [15:0] exp_steps();
        return 16'(q.size() - steps_base - n_clear);
    endfunction

    task automatic stop_seq();
        int c;
        int k = 0;
        cfg_wr(CFG_CTRL, 32'h0, c);
        while (busy === 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_miss++; $display("FAIL stop_busy: got %b, expected 0", busy);
        end
        n_vec++;
        if (q.size() == 0 || q[q.size()-1].data !== 32'h0) begin
            n_miss++; $display("FAIL stop_clear: last write not 0 (writes=%0d)", q.size());
        end
        n_clear++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int b;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        steps_base = q.size();
        n_clear = 0;
        n_vec++;
        if (cfg_readdata !== 32'h0 || busy !== 1'b0 || led_write !== 1'b0 || led_writedata !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_outputs: got rd=%h busy=%b wr=%b wd=%h, expected all 0",
                     cfg_readdata, busy, led_write, led_writedata);
        end
        cfg_rd(CFG_STATUS, d);
        n_vec++;
        if (d !== 32'h0) begin n_miss++; $display("FAIL reset_status: got %h, expected 0", d); end
        cfg_rd(CFG_PERIOD, d);
        n_vec++;
        if (d !== 32'd50_000_000) begin n_miss++; $display("FAIL reset_period: got %0d, expected 50000000", d); end
        cfg_rd(CFG_CTRL, d);
        n_vec++;
        if (d !== 32'h0) begin n_miss++; $display("FAIL reset_ctrl: got %h, expected 0", d); end
        b = q.size();
        tick(100);
        n_vec++;
        if (q.size() != b) begin n_miss++; $display("FAIL reset_idle: got %0d writes, expected 0", q.size() - b); end
    endtask

    task automatic test_rotate();
        int b, c0;
        bit ok;
        logic [31:0] exp;
        cfg_wr(CFG_PERIOD, 32'd4, c0);
        cfg_wr(CFG_PATTERN, 32'h001, c0);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h5, c0);
        wait_writes(b + 12, 120, "rotate", ok);
        if (ok) begin
            n_vec++;
            if (q[b].cyc != c0 + 1) begin
                n_miss++; $display("FAIL rotate_latency: got cycle %0d, expected %0d", q[b].cyc, c0 + 1);
            end
            for (int i = 0; i < 12; i++) begin
                exp = 32'h1 << (i % 10);
                n_vec++;
                if (q[b+i].data !== exp) begin
                    n_miss++; $display("FAIL rotate_data[%0d]: got %h, expected %h", i, q[b+i].data, exp);
                end
                if (i > 0) begin
                    n_vec++;
                    if (q[b+i].cyc - q[b+i-1].cyc != 6) begin
                        n_miss++; $display("FAIL rotate_gap[%0d]: got %0d, expected 6", i, q[b+i].cyc - q[b+i-1].cyc);
                    end
                end
            end
        end
        stop_seq();
    endtask

    task automatic test_blink();
        int b, c;
        bit ok;
        logic [31:0] exp;
        logic [31:0] d;
        cfg_wr(CFG_PERIOD, 32'd0, c);
        cfg_wr(CFG_PATTERN, 32'h155, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h3, c);
        wait_writes(b + 3, 40, "blink", ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                exp = (i % 2 == 0) ? 32'h155 : 32'h2AA;
                n_vec++;
                if (q[b+i].data !== exp) begin
                    n_miss++; $display("FAIL blink_data[%0d]: got %h, expected %h", i, q[b+i].data, exp);
                end
                if (i > 0) begin
                    n_vec++;
                    if (q[b+i].cyc - q[b+i-1].cyc != 3) begin
                        n_miss++; $display("FAIL blink_gap[%0d]: got %0d, expected 3", i, q[b+i].cyc - q[b+i-1].cyc);
                    end
                end
            end
        end
        cfg_rd(CFG_STATUS, d);
        n_vec++;
        if (d[0] !== 1'b1) begin n_miss++; $display("FAIL blink_busy_bit: got %b, expected 1", d[0]); end
        stop_seq();
        cfg_rd(CFG_STATUS, d);
        exp = {exp_steps(), 16'h0000};
        n_vec++;
        if (d !== exp) begin n_miss++; $display("FAIL blink_steps: got %h, expected %h", d, exp); end
    endtask

    task automatic test_bounce();
        int b, c;
        bit ok;
        logic [31:0] exp;
        cfg_wr(CFG_PERIOD, 32'd0, c);
        cfg_wr(CFG_PATTERN, 32'h200, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h7, c);
        wait_writes(b + 3, 40, "bounce_msb", ok);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                exp = 32'h200 >> i;
                n_vec++;
                if (q[b+i].data !== exp) begin
                    n_miss++; $display("FAIL bounce_msb[%0d]: got %h, expected %h", i, q[b+i].data, exp);
                end
            end
        end
        stop_seq();
        cfg_wr(CFG_PATTERN, 32'h001, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h7, c);
        wait_writes(b + 20, 100, "bounce_lsb", ok);
        if (ok) begin
            for (int i = 0; i < 20; i++) begin
                if (i <= 9)       exp = 32'h1 << i;
                else if (i <= 18) exp = 32'h1 << (18 - i);
                else              exp = 32'h2;
                n_vec++;
                if (q[b+i].data !== exp) begin
                    n_miss++; $display("FAIL bounce_lsb[%0d]: got %h, expected %h", i, q[b+i].data, exp);
                end
            end
        end
        stop_seq();
    endtask

    task automatic test_reload();
        int b, c;
        bit ok;
        cfg_wr(CFG_PERIOD, 32'd8, c);
        cfg_wr(CFG_PATTERN, 32'h00F, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h1, c);
        wait_writes(b + 1, 20, "reload_first", ok);
        tick(3);
        cfg_wr(CFG_PATTERN, 32'h0F0, c);
        wait_writes(b + 3, 40, "reload", ok);
        if (ok) begin
            n_vec++;
            if (q[b].data !== 32'h00F) begin n_miss++; $display("FAIL reload_first: got %h, expected 00f", q[b].data); end
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (q[b+i].data !== 32'h0F0) begin
                    n_miss++; $display("FAIL reload_data[%0d]: got %h, expected 0f0", i, q[b+i].data);
                end
                n_vec++;
                if (q[b+i].cyc - q[b+i-1].cyc != 10) begin
                    n_miss++; $display("FAIL reload_gap[%0d]: got %0d, expected 10", i, q[b+i].cyc - q[b+i-1].cyc);
                end
            end
        end
        stop_seq();
    endtask

    task automatic test_period_shrink();
        int b, c, c0;
        bit ok;
        cfg_wr(CFG_PERIOD, 32'd30, c);
        cfg_wr(CFG_PATTERN, 32'h3C3, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h1, c);
        wait_writes(b + 1, 20, "shrink_first", ok);
        tick(5);
        cfg_wr(CFG_PERIOD, 32'd2, c0);
        wait_writes(b + 3, 60, "shrink", ok);
        if (ok) begin
            n_vec++;
            if (q[b+1].cyc != c0 + 2) begin
                n_miss++; $display("FAIL shrink_immediate: got cycle %0d, expected %0d", q[b+1].cyc, c0 + 2);
            end
            n_vec++;
            if (q[b+2].cyc - q[b+1].cyc != 4) begin
                n_miss++; $display("FAIL shrink_gap: got %0d, expected 4", q[b+2].cyc - q[b+1].cyc);
            end
            n_vec++;
            if (q[b+2].data !== 32'h3C3) begin
                n_miss++; $display("FAIL shrink_data: got %h, expected 3c3", q[b+2].data);
            end
        end
        stop_seq();
    endtask

    task automatic test_stop_in_wait();
        int b, c, c0;
        bit ok;
        cfg_wr(CFG_PERIOD, 32'd20, c);
        cfg_wr(CFG_PATTERN, 32'h3FF, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h1, c);
        wait_writes(b + 1, 20, "stop_first", ok);
        cfg_wr(CFG_CTRL, 32'h0, c0);
        wait_writes(b + 2, 10, "stop", ok);
        if (ok) begin
            n_vec++;
            if (q[b+1].data !== 32'h0) begin n_miss++; $display("FAIL stop_zero: got %h, expected 0", q[b+1].data); end
            n_vec++;
            if (q[b+1].cyc <= c0 || q[b+1].cyc > c0 + 2) begin
                n_miss++; $display("FAIL stop_latency: got cycle %0d, expected %0d..%0d", q[b+1].cyc, c0 + 1, c0 + 2);
            end
        end
        n_clear++;
        tick(25);
        n_vec++;
        if (q.size() != b + 2) begin n_miss++; $display("FAIL stop_single: got %0d writes, expected 2", q.size() - b); end
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL stop_idle: got busy %b, expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int b, c;
        bit ok;
        logic [31:0] d;
        cfg_wr(CFG_PERIOD, 32'd20, c);
        cfg_wr(CFG_PATTERN, 32'h001, c);
        b = q.size();
        cfg_wr(CFG_CTRL, 32'h5, c);
        wait_writes(b + 1, 20, "abort_first", ok);
        tick(5);
        reset = 1'b1;
        tick(1);
        n_vec++;
        if (led_write !== 1'b0 || led_chipselect !== 1'b0 || led_writedata !== 32'h0 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL abort_outputs: got wr=%b cs=%b wd=%h busy=%b, expected all 0",
                     led_write, led_chipselect, led_writedata, busy);
        end
        tick(1);
        reset = 1'b0;
        steps_base = q.size();
        n_clear = 0;
        tick(30);
        n_vec++;
        if (q.size() != steps_base) begin n_miss++; $display("FAIL abort_quiet: got %0d writes, expected 0", q.size() - steps_base); end
        cfg_rd(CFG_STATUS, d);
        n_vec++;
        if (d !== 32'h0) begin n_miss++; $display("FAIL abort_status: got %h, expected 0", d); end
        cfg_rd(CFG_PERIOD, d);
        n_vec++;
        if (d !== 32'd50_000_000) begin n_miss++; $display("FAIL abort_period: got %0d, expected 50000000", d); end
    endtask

    task automatic test_led_port();
        n_vec++;
        if (proto_err != 0) begin n_miss++; $display("FAIL led_port_protocol: got %0d bad cycles, expected 0", proto_err); end
    endtask

    initial begin
        reset          = 1'b1;
        cfg_address    = 2'h0;
        cfg_chipselect = 1'b0;
        cfg_read       = 1'b0;
        cfg_write      = 1'b0;
        cfg_writedata  = 32'h0;
        test_reset();
        test_rotate();
        test_blink();
        test_bounce();
        test_reload();
        test_period_shrink();
        test_stop_in_wait();
        test_reset_abort();
        test_led_port();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
